// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: FSM encodings,
// grant ids, address-extension constant and default abort limit.
package mem_arb_defs;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam logic [15:0] ADDR_EXT_ZERO = 16'h0000;

    localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin select between instruction fetch and data access;
// on a tie the side that did not win last time is chosen.
module mem_arb_rr_pick
    import mem_arb_defs::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic valid,
    output logic gnt
);

    always_comb begin
        valid = if_req | d_req;
        if (if_req && d_req)
            gnt = ~last_grant;
        else if (d_req)
            gnt = GNT_DATA;
        else
            gnt = GNT_INSTR;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a req/ack handshake.
// Define ARB_ACCESS_TIMEOUT_EN to abort accesses that memory never acknowledges.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int ADDR_IN_W = 16,
    parameter int DATA_W    = 32
`ifdef ARB_ACCESS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [ADDR_IN_W-1:0] if_addr,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_IN_W-1:0] d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 access_err
);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;

`ifdef ARB_ACCESS_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    logic pick_valid;
    logic pick_gnt;

    mem_arb_rr_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .gnt        (pick_gnt)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
`ifdef ARB_ACCESS_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d        = pick_gnt;
                    last_grant_d = pick_gnt;
                    mem_req_d    = 1'b1;
                    if (pick_gnt == GNT_DATA) begin
                        mem_addr_d  = {ADDR_EXT_ZERO, d_addr};
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_addr_d  = {ADDR_EXT_ZERO, if_addr};
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
`ifdef ARB_ACCESS_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                // A completing ack takes priority over a timeout on the same edge.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        if (gnt_q == GNT_DATA)
                            d_rdata_d = mem_rdata;
                        else
                            if_rdata_d = mem_rdata;
                    end
                    if_ack_d = (gnt_q == GNT_INSTR);
                    d_ack_d  = (gnt_q == GNT_DATA);
                    state_d  = RESP;
                end
`ifdef ARB_ACCESS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LIMIT) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (gnt_q == GNT_DATA)
                        d_rdata_d = '0;
                    else
                        if_rdata_d = '0;
                    if_ack_d = (gnt_q == GNT_INSTR);
                    d_ack_d  = (gnt_q == GNT_DATA);
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end

            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it lives inside the clocked branch.
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_INSTR;
            last_grant_q <= GNT_INSTR;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
`ifdef ARB_ACCESS_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
`ifdef ARB_ACCESS_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;

`ifdef ARB_ACCESS_TIMEOUT_EN
    assign access_err = err_q;
`else
    assign access_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and the data load/store path (MEM stage) of the DLX core.
- Widens each requester's 16-bit address to the 32-bit bus address by zero-extension: upper 16 bits 0x0000.
- Sequences each access with a req/ack handshake toward memory and a one-cycle ack pulse back to the requester.
- Sits between the pipeline stage interfaces and the memory/bus model.

Parameters:
- ADDR_IN_W, 16, requester address width; zero-extended to 32 bits.
- DATA_W, 32, data bus width.
- TIMEOUT_CYCLES, 15, ACCESS cycles allowed before abort (only with the optional feature); must be at least 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request; held until if_ack
- if_addr  in  16  fetch address; stable while if_req high
- if_rdata  out  32  fetched word; valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load; stable while d_req high
- d_addr  in  16  data address; stable while d_req high
- d_wdata  in  32  store data; stable while d_req high
- d_rdata  out  32  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory access strobe; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  {16'h0000, granted addr}
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid with mem_ack
- mem_ack  in  1  memory completion; sampled only in ACCESS
- access_err  out  1  one-cycle abort pulse, coincident with requester ack

Behaviour:
- One clock (clk); synchronous active-high reset (reset). All outputs are registered.
- Reset state:
  - state=IDLE, last_grant=INSTR (so data wins the first tie).
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, access_err=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples if_req and d_req.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant. This alternates, so neither side starves.
  - On grant: latch grant id, mem_addr={16'h0000,addr}, mem_we (d_we for data, 0 for fetch) and mem_wdata (d_wdata for data, 0 for fetch). Set mem_req=1 and update last_grant. Next state is ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Holds mem_req and all mem_* outputs stable.
  - On an edge where mem_ack=1: clear mem_req and mem_we; capture mem_rdata into the granted requester's rdata (loads and fetches only; a store leaves rdata unchanged). Next state is RESP.
- RESP:
  - The granted requester's ack is 1 for exactly this cycle.
  - The other ack and all mem_* strobes are 0. Next state is IDLE.
  - The requester must drop req on the edge ending RESP.
- Latency: req high in IDLE at edge 0 → mem_req high from cycle 1. Memory acking in cycle 1 → requester ack in cycle 2. Each memory wait state adds one cycle.
- Back-to-back: at least one IDLE cycle separates accesses, so a stale req is never re-granted.
- rdata holds its value until the next completion for that requester.
- mem_ack outside ACCESS is ignored.
- Reset mid-operation:
  - Any state goes to IDLE and all strobes drop at that edge.
  - An in-flight memory access is abandoned; no ack is issued.
- Requester-side protocol violations (req dropped before ack) are not detected. The granted access completes, and its ack pulse is still produced.

Optional Feature:
- Macro ARB_ACCESS_TIMEOUT_EN.
- Defined:
  - A 4-bit watchdog counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES without mem_ack, the access aborts: mem_req drops, the requester's rdata is loaded with 32'h0000_0000, and the FSM goes to RESP.
  - In that RESP cycle access_err=1 together with the requester ack.
  - If mem_ack arrives on the same edge as the limit, mem_ack wins and there is no error.
- Undefined: the counter is absent, ACCESS waits indefinitely, and access_err is tied to 0.

Decomposition:
- Shared package/header mem_arb_defs:
  - State encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Grant ids: GNT_INSTR=1'b0, GNT_DATA=1'b1.
  - ADDR_EXT_ZERO=16'h0000.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, mem_arb_rr_pick: combinational two-way round-robin select from {if_req, d_req, last_grant}. The FSM and datapath stay in mem_port_arbiter.

Test Plan:
- Fetch only, zero-wait memory:
  - Stimulus: if_req=1, if_addr=16'h0040, memory acks in the first ACCESS cycle with mem_rdata=32'h2001_0005.
  - Response: mem_addr=32'h0000_0040 and mem_we=0; if_ack in cycle 2 with if_rdata=32'h2001_0005; d_ack stays 0.
- Store with 3 wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=16'hFFFC, d_wdata=32'hCAFE_F00D.
  - Response: mem_addr=32'h0000_FFFC; mem_req, mem_we and mem_wdata stable for 4 cycles; d_ack one cycle after mem_ack; d_rdata unchanged.
- Simultaneous requests after reset, both held:
  - Response: data granted first, then fetch.
  - Repeating with both held gives grants alternating D,I,D,I, with one IDLE cycle between each access.
- Reset during ACCESS:
  - Stimulus: assert reset for one cycle while mem_req=1.
  - Response: the next cycle shows IDLE, mem_req=0, no ack; the same request is served afresh afterwards.
- Stray mem_ack=1 during IDLE and RESP:
  - Response: no state change, no extra ack pulses.
- With ARB_ACCESS_TIMEOUT_EN:
  - Memory never acks a load at 16'h1234: after 15 ACCESS cycles, d_ack=1 with access_err=1 and d_rdata=0.
  - mem_ack on exactly the 15th cycle: normal completion with access_err=0.
